// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT,
      RELEASE
   } arb_state_t;

   // Start bit + 8 data bits + stop bit.
   localparam int UART_FRAME_BITS = 10;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit scanning ptr, ptr+1, ... modulo NUM_REQ.
module rr_pick
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   winner,
   output logic               any
);

   localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

   logic [IDX_W:0] pos;

   // Scan from the farthest offset down so the offset closest to ptr wins;
   // the explicit subtract keeps the wrap correct for non-power-of-2 NUM_REQ.
   always_comb begin
      winner = '0;
      pos    = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         pos = {1'b0, ptr} + (IDX_W + 1)'(k);
         if (pos >= NUM_REQ_W) pos = pos - NUM_REQ_W;
         if (req[pos[IDX_W-1:0]]) winner = pos[IDX_W-1:0];
      end
   end

   assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters,
// with per-requester ack on frame completion and err when the UART never accepts.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          ack,
   output logic [NUM_REQ-1:0]          err,
   output logic                        grant_valid,
   output logic [$clog2(NUM_REQ)-1:0]  grant_idx,
   output logic                        uart_send,
   output logic [DATA_W-1:0]           uart_data,
   input  logic                        uart_done
);

   localparam int IDX_W = idx_w(NUM_REQ);
   localparam int TMR_W = idx_w(TIMEOUT);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   arb_state_t          state_q, state_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
   logic                grant_valid_q, grant_valid_d;
   logic                uart_send_q, uart_send_d;
   logic [DATA_W-1:0]   uart_data_q, uart_data_d;
   logic [NUM_REQ-1:0]  ack_q, ack_d;
   logic [NUM_REQ-1:0]  err_q, err_d;

   logic [IDX_W-1:0]    winner;
   logic                any;
   logic [DATA_W-1:0]   sel_data;
   logic [NUM_REQ-1:0]  grant_onehot;
   logic [IDX_W-1:0]    next_ptr;
   logic                start_grant;
   logic                timer_expired;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req    (req),
      .ptr    (ptr_q),
      .winner (winner),
      .any    (any)
   );

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner == IDX_W'(i)) sel_data = req_data[i*DATA_W +: DATA_W];
      end
   end

   assign grant_onehot  = NUM_REQ'(1) << grant_idx_q;
   assign next_ptr      = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + IDX_W'(1);
   assign start_grant   = any && uart_done;
   assign timer_expired = (timer_q == TMR_LAST);

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         timer_q       <= '0;
         grant_idx_q   <= '0;
         grant_valid_q <= 1'b0;
         uart_send_q   <= 1'b0;
         uart_data_q   <= '0;
         ack_q         <= '0;
         err_q         <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         timer_q       <= timer_d;
         grant_idx_q   <= grant_idx_d;
         grant_valid_q <= grant_valid_d;
         uart_send_q   <= uart_send_d;
         uart_data_q   <= uart_data_d;
         ack_q         <= ack_d;
         err_q         <= err_d;
      end
   end

   // NOTE: each combinational block assigns a default to every output first,
   // so no path through the case can leave a value unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start_grant) state_d = START;
         START: begin
            if (!uart_done)         state_d = WAIT;
            else if (timer_expired) state_d = RELEASE;
         end
         WAIT:    if (uart_done) state_d = RELEASE;
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ptr_d         = ptr_q;
      timer_d       = timer_q;
      grant_idx_d   = grant_idx_q;
      grant_valid_d = grant_valid_q;
      uart_send_d   = uart_send_q;
      uart_data_d   = uart_data_q;
      ack_d         = '0;
      err_d         = '0;
      unique case (state_q)
         IDLE: begin
            if (start_grant) begin
               grant_idx_d   = winner;
               uart_data_d   = sel_data;
               uart_send_d   = 1'b1;
               grant_valid_d = 1'b1;
               timer_d       = '0;
            end
         end
         START: begin
            if (!uart_done) begin
               uart_send_d = 1'b0;
            end else if (timer_expired) begin
               // UART never went busy: drop the request and move past this requester.
               uart_send_d = 1'b0;
               err_d       = grant_onehot;
               ptr_d       = next_ptr;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         WAIT: begin
            if (uart_done) begin
               ack_d = grant_onehot;
               ptr_d = next_ptr;
            end
         end
         RELEASE: begin
            grant_valid_d = 1'b0;
         end
         default: begin
            grant_valid_d = 1'b0;
            uart_send_d   = 1'b0;
         end
      endcase
   end

   assign ack         = ack_q;
   assign err         = err_q;
   assign grant_valid = grant_valid_q;
   assign grant_idx   = grant_idx_q;
   assign uart_send   = uart_send_q;
   assign uart_data   = uart_data_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (send/data/done handshake, one bit per clock, 10-bit frame) among NUM_REQ byte requesters.
- Picks requesters in round-robin order, latches the winner's byte and drives the UART send handshake.
- Reports per-requester completion (ack) or timeout (err).
- Sits between firmware/debug byte sources and the UART TX block.

Parameters:
- NUM_REQ, 4: number of requesters (2..16, non-power-of-2 allowed).
- DATA_W, 8: byte width.
- TIMEOUT, 16: max cycles in START waiting for uart_done to fall before abort (>=2).

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  level; req[i]=1 means requester i has a byte pending; held until ack[i] or err[i].
- req_data  in  NUM_REQ*DATA_W  packed; requester i at [i*DATA_W +: DATA_W]; stable while req[i]=1.
- ack  out  NUM_REQ  one-cycle pulse: requester's byte fully sent, stop bit done.
- err  out  NUM_REQ  one-cycle pulse: UART never accepted the byte; request dropped.
- grant_valid  out  1  a transfer is owned, START through RELEASE.
- grant_idx  out  $clog2(NUM_REQ)  current/last owner.
- uart_send  out  1  send strobe to UART.
- uart_data  out  DATA_W  byte to UART, held through START.
- uart_done  in  1  UART idle (1) / busy (0).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (async, immediate, including mid-transfer):
  - state=IDLE, ptr=0, timer=0.
  - uart_send=0, uart_data=0, ack=0, err=0, grant_valid=0, grant_idx=0.
  - An aborted frame is not acked.
- All outputs are registered.
- FSM states: IDLE, START, WAIT, RELEASE.
- IDLE:
  - Acts only if |req and uart_done=1. If uart_done=0, stay.
  - Winner = first set bit of req scanning ptr, ptr+1, ... wrapping modulo NUM_REQ.
  - Next edge: grant_idx<=winner, uart_data<=req_data[winner], uart_send<=1, grant_valid<=1, timer<=0, ->START.
  - Latency from req rise to uart_send=1 is 1 cycle.
- START (uart_send held 1):
  - If uart_done=0: uart_send<=0, ->WAIT.
  - Else timer++. When timer==TIMEOUT-1: uart_send<=0, err[grant_idx]<=1, ptr<=(grant_idx+1) mod NUM_REQ, ->RELEASE.
- WAIT:
  - Wait for uart_done=1 (frame complete). No timeout.
  - Then ack[grant_idx]<=1, ptr<=(grant_idx+1) mod NUM_REQ, ->RELEASE.
- RELEASE: one cycle; ack/err high this cycle; req ignored. Requester drops req at this edge. ack,err<=0, grant_valid<=0, ->IDLE.
- Bandwidth: one byte per (UART frame + 3) cycles minimum. No back-to-back re-grant of the same requester while others wait.
- Boundary and corner rules:
  - req[i] drops mid-transfer: the transfer still completes, and ack[i] still pulses.
  - req_data changes after grant: no effect (latched).
  - Non-granted req bits: ignored until IDLE.
  - Exactly one of ack/err pulses per grant, never both, and only for grant_idx.
  - ptr wraps NUM_REQ-1 -> 0 explicitly; no power-of-2 assumption.

Decomposition:
- Package uart_pkg:
  - enum arb_state_t {IDLE, START, WAIT, RELEASE}.
  - localparam UART_FRAME_BITS=10.
  - function clog2-safe index width.
- Sub-module rr_pick: purely combinational.
  - Inputs: req vector, ptr.
  - Outputs: winner index, any.
  - Implementation: double-width rotate or masked priority encode.

Test Plan:
- Behavioural UART model for all scenarios: done falls 2 cycles after send sampled, rises 10 cycles later.
- Single requester: req=4'b0100, req_data[2]=8'h47 -> uart_send high 1 cycle after req; uart_data=8'h47; one ack[2] pulse; ack=0 elsewhere; grant_idx=2.
- All four requesting from reset, data 8'h10,8'h21,8'h32,8'h43 -> UART sees 10,21,32,43 in order. Requester 0 re-raises req, and requester 3 remains: next grant is 3 before 0.
- UART model holds done=1 forever, TIMEOUT=16 -> uart_send high exactly 16 cycles. err[grant] pulses once, no ack, ptr advances, state back to IDLE.
- reset_n pulled low during WAIT of requester 1 -> uart_send, grant_valid, ack go 0 asynchronously. After release, the first grant goes to requester 0 (ptr=0), no ack[1].
- req[1] dropped and req_data[1] changed 3 cycles after grant -> original byte transmitted and ack[1] still pulses. uart_done held low in IDLE for 5 cycles -> no grant until it rises.
